// File: rtl/wm_port_arbiter.sv
// Purpose : round-robin arbiter giving the single weight-memory port to host write bursts or CU read bursts.
// Latency : grant one cycle after the request is sampled in IDLE; read data and rvalid one cycle after each CU beat.
// Backpressure: requesters hold their req level until gnt; a burst runs to completion, and at least one IDLE cycle separates bursts.
//
// Ports: clk/reset (async, active-high); host_* is the write-burst requester; cu_* is the read-burst requester;
//        wm_* is the memory port; state_out is the debug FSM state; perf_* are the optional performance counters.
// Optional feature: define WM_ARB_PERF_EN to enable the saturating perf counters. When it is undefined, the perf ports read 0.
module wm_port_arbiter #(
    parameter int DATA_WIDTH_WMEMORY   = 64,
    parameter int ADDRESS_SIZE_WMEMORY = 32,
    parameter int BURST_W              = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            host_req,
    input  logic [ADDRESS_SIZE_WMEMORY-1:0] host_addr,
    input  logic [BURST_W-1:0]              host_len,
    input  logic [DATA_WIDTH_WMEMORY-1:0]   host_wdata,
    output logic                            host_gnt,
    output logic                            host_beat,
    output logic                            host_done,
    input  logic                            cu_req,
    input  logic [ADDRESS_SIZE_WMEMORY-1:0] cu_addr,
    input  logic [BURST_W-1:0]              cu_len,
    output logic                            cu_gnt,
    output logic                            cu_rvalid,
    output logic [DATA_WIDTH_WMEMORY-1:0]   cu_rdata,
    output logic                            wm_ce,
    output logic                            wm_we,
    output logic [ADDRESS_SIZE_WMEMORY-1:0] wm_address,
    output logic [DATA_WIDTH_WMEMORY-1:0]   wm_din,
    input  logic [DATA_WIDTH_WMEMORY-1:0]   wm_dout,
    output logic [1:0]                      state_out,
    output logic [31:0]                     perf_host_beats,
    output logic [31:0]                     perf_cu_beats,
    output logic [31:0]                     perf_conflicts
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_HOST = 2'd1,
        GNT_CU   = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic                              last_cu_q, last_cu_d;   // 1: CU got the last grant
    logic [ADDRESS_SIZE_WMEMORY-1:0]   base_q, base_d;
    logic [BURST_W-1:0]                len_q, len_d;
    logic [BURST_W-1:0]                idx_q, idx_d;
    logic                              rvalid_q, rvalid_d;
    logic                              done_q, done_d;
    logic                              last_beat;

    assign last_beat = (idx_q == len_q - BURST_W'(1));

    always_comb begin
        state_d    = state_q;
        last_cu_d  = last_cu_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        rvalid_d   = 1'b0;
        done_d     = 1'b0;
        host_gnt   = 1'b0;
        host_beat  = 1'b0;
        cu_gnt     = 1'b0;
        wm_ce      = 1'b0;
        wm_we      = 1'b0;
        wm_address = '0;
        wm_din     = '0;
        case (state_q)
            IDLE: begin
                // On a tie, the side that did not get the previous grant wins.
                if (cu_req && (!host_req || !last_cu_q)) begin
                    state_d   = GNT_CU;
                    base_d    = cu_addr;
                    len_d     = (cu_len == '0) ? BURST_W'(1) : cu_len;
                    idx_d     = '0;
                    last_cu_d = 1'b1;
                end else if (host_req) begin
                    state_d   = GNT_HOST;
                    base_d    = host_addr;
                    len_d     = (host_len == '0) ? BURST_W'(1) : host_len;
                    idx_d     = '0;
                    last_cu_d = 1'b0;
                end
            end
            GNT_HOST: begin
                host_gnt   = 1'b1;
                host_beat  = 1'b1;
                wm_ce      = 1'b1;
                wm_we      = 1'b1;
                wm_address = base_q + ADDRESS_SIZE_WMEMORY'(idx_q);
                wm_din     = host_wdata;
                idx_d      = idx_q + BURST_W'(1);
                if (last_beat) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            GNT_CU: begin
                cu_gnt     = 1'b1;
                wm_ce      = 1'b1;
                wm_address = base_q + ADDRESS_SIZE_WMEMORY'(idx_q);
                idx_d      = idx_q + BURST_W'(1);
                rvalid_d   = 1'b1;
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_cu_q <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rvalid_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_cu_q <= last_cu_d;
            base_q    <= base_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rvalid_q  <= rvalid_d;
            done_q    <= done_d;
        end
    end

    // The memory's own read register supplies the data, so it is aligned with rvalid_q.
    // The data is gated to 0 between beats.
    assign cu_rvalid = rvalid_q;
    assign cu_rdata  = rvalid_q ? wm_dout : '0;
    assign host_done = done_q;
    assign state_out = state_q;

`ifdef WM_ARB_PERF_EN
    logic [31:0] perf_host_beats_q, perf_host_beats_d;
    logic [31:0] perf_cu_beats_q, perf_cu_beats_d;
    logic [31:0] perf_conflicts_q, perf_conflicts_d;

    always_comb begin
        perf_host_beats_d = perf_host_beats_q;
        perf_cu_beats_d   = perf_cu_beats_q;
        perf_conflicts_d  = perf_conflicts_q;
        if (state_q == GNT_HOST && perf_host_beats_q != '1)
            perf_host_beats_d = perf_host_beats_q + 32'd1;
        if (state_q == GNT_CU && perf_cu_beats_q != '1)
            perf_cu_beats_d = perf_cu_beats_q + 32'd1;
        if (state_q == IDLE && host_req && cu_req && perf_conflicts_q != '1)
            perf_conflicts_d = perf_conflicts_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_host_beats_q <= '0;
            perf_cu_beats_q   <= '0;
            perf_conflicts_q  <= '0;
        end else begin
            perf_host_beats_q <= perf_host_beats_d;
            perf_cu_beats_q   <= perf_cu_beats_d;
            perf_conflicts_q  <= perf_conflicts_d;
        end
    end

    assign perf_host_beats = perf_host_beats_q;
    assign perf_cu_beats   = perf_cu_beats_q;
    assign perf_conflicts  = perf_conflicts_q;
`else
    assign perf_host_beats = '0;
    assign perf_cu_beats   = '0;
    assign perf_conflicts  = '0;
`endif

endmodule
